// File: rtl/inv_byte_permutation_pkg.sv
// ============================================================================
// aes_pkg : shared AES byte-serial constants, index type and ShiftRows maps
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package aes_pkg;

  localparam int STATE_BYTES = 16;

  typedef logic [3:0] byte_idx_t;

  localparam byte_idx_t LAST_IDX = byte_idx_t'(STATE_BYTES - 1);

  // Column-major index k = {col, row}; InvShiftRows takes row r from column c - r.
  function automatic byte_idx_t inv_shift_src(byte_idx_t k);
    logic [1:0] col;
    col = k[3:2] - k[1:0];
    return {col, k[1:0]};
  endfunction

  function automatic byte_idx_t shift_src(byte_idx_t k);
    logic [1:0] col;
    col = k[3:2] + k[1:0];
    return {col, k[1:0]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/inv_byte_permutation_if.sv
// ============================================================================
// inv_byte_permutation_if : input and output byte streams with valid/ready
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

interface inv_byte_permutation_if;

  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

endinterface

`default_nettype wire

// File: rtl/inv_byte_permutation_state_bank.sv
// ============================================================================
// state_bank : 16x8 flop array, one write port, one combinational read port
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module state_bank
  import aes_pkg::*;
(
  input  wire logic       clk,
  input  wire logic       rst_n,
  input  wire logic       i_we,
  input  wire byte_idx_t  i_waddr,
  input  wire logic [7:0] i_wdata,
  input  wire byte_idx_t  i_raddr,
  output logic      [7:0] o_rdata
);

  logic [7:0] r_mem [STATE_BYTES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STATE_BYTES; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

`default_nettype wire

// File: rtl/inv_byte_permutation.sv
// ============================================================================
// inv_byte_permutation : byte-serial InvShiftRows with a ping-pong block buffer
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module inv_byte_permutation
  import aes_pkg::*;
(
  input  wire logic              clk,
  input  wire logic              rst_n,
  input  wire logic              i_flush,
  inv_byte_permutation_if.slave  s_bus
);

  logic       r_wr_bank;
  logic       r_rd_bank;
  byte_idx_t  r_wr_cnt;
  byte_idx_t  r_rd_cnt;
  logic [1:0] r_full;

  logic       w_in_ready;
  logic       w_out_valid;
  logic       w_wr_fire;
  logic       w_rd_fire;
  logic       w_wr_done;
  logic       w_rd_done;
  logic [1:0] w_full_nxt;
  logic [1:0] w_bank_we;
  byte_idx_t  w_rd_addr;
  logic [7:0] w_bank_rdata [2];

  assign w_in_ready  = ~r_full[r_wr_bank];
  assign w_out_valid = r_full[r_rd_bank];
  assign w_wr_fire   = s_bus.in_valid && w_in_ready;
  assign w_rd_fire   = w_out_valid && s_bus.out_ready;
  assign w_wr_done   = w_wr_fire && (r_wr_cnt == LAST_IDX);
  assign w_rd_done   = w_rd_fire && (r_rd_cnt == LAST_IDX);
  assign w_rd_addr   = inv_shift_src(r_rd_cnt);

  for (genvar b = 0; b < 2; b++) begin : g_bank
    assign w_bank_we[b] = w_wr_fire && !i_flush && (r_wr_bank == 1'(b));

    state_bank u_bank (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_we    (w_bank_we[b]),
      .i_waddr (r_wr_cnt),
      .i_wdata (s_bus.in_data),
      .i_raddr (w_rd_addr),
      .o_rdata (w_bank_rdata[b])
    );
  end

  // A write can only complete into an empty bank and a read only out of a full
  // one, so the two updates below never touch the same flag.
  always_comb begin
    w_full_nxt = r_full;
    if (w_wr_done) begin
      w_full_nxt[r_wr_bank] = 1'b1;
    end
    if (w_rd_done) begin
      w_full_nxt[r_rd_bank] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_bank <= 1'b0;
      r_rd_bank <= 1'b0;
      r_wr_cnt  <= '0;
      r_rd_cnt  <= '0;
      r_full    <= 2'b00;
    end else if (i_flush) begin
      r_wr_bank <= 1'b0;
      r_rd_bank <= 1'b0;
      r_wr_cnt  <= '0;
      r_rd_cnt  <= '0;
      r_full    <= 2'b00;
    end else begin
      if (w_wr_fire) begin
        r_wr_cnt <= r_wr_cnt + 4'd1;
      end
      if (w_wr_done) begin
        r_wr_bank <= ~r_wr_bank;
      end
      if (w_rd_fire) begin
        r_rd_cnt <= r_rd_cnt + 4'd1;
      end
      if (w_rd_done) begin
        r_rd_bank <= ~r_rd_bank;
      end
      r_full <= w_full_nxt;
    end
  end

  assign s_bus.in_ready  = w_in_ready;
  assign s_bus.out_valid = w_out_valid;
  assign s_bus.out_data  = w_bank_rdata[r_rd_bank];
  assign s_bus.out_last  = w_out_valid && (r_rd_cnt == LAST_IDX);

  a_hold_data : assert property (@(posedge clk) disable iff (!rst_n)
    (w_out_valid && !s_bus.out_ready && !i_flush) |=> $stable(s_bus.out_data));

  a_distinct_banks : assert property (@(posedge clk) disable iff (!rst_n)
    (w_wr_done && w_rd_done) |-> (r_wr_bank != r_rd_bank));

endmodule

`default_nettype wire

// File: tb/tb_inv_byte_permutation.sv
// Bench for inv_byte_permutation: directed tables, FIPS-197 round trip,
// backpressure, flush and asynchronous reset sequences.
`timescale 1ns/1ps

module tb_inv_byte_permutation;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;

  int checks = 0;
  int errors = 0;

  inv_byte_permutation_if bus ();

  inv_byte_permutation dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (flush),
    .s_bus   (bus)
  );

  always #5 clk = ~clk;

  typedef logic [7:0] blk_t [16];
  typedef struct {
    logic [7:0] din;
    logic [7:0] dout;
    logic       last;
  } vec_t;

  vec_t       vec1 [16];
  vec_t       vec2 [16];
  logic [7:0] exp_q [$];
  logic [7:0] tx_q  [$];
  int         rx_cnt  = 0;
  int         rdy_pct = 0;
  bit         mon_en  = 1'b0;
  bit         prev_stall = 1'b0;
  logic [7:0] prev_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Forward ShiftRows: output (r,c) takes input (r, (c+r) mod 4), column-major.
  function automatic int fwd_src(int k);
    int r;
    int c;
    r = k % 4;
    c = k / 4;
    return ((c + r) % 4) * 4 + r;
  endfunction

  task automatic add_block(input blk_t orig);
    for (int k = 0; k < 16; k++) exp_q.push_back(orig[k]);
    for (int k = 0; k < 16; k++) tx_q.push_back(orig[fwd_src(k)]);
  endtask

  task automatic add_rand_block();
    blk_t b;
    for (int k = 0; k < 16; k++) b[k] = 8'($urandom);
    add_block(b);
  endtask

  task automatic send_bytes(input logic [7:0] q [$], input int vpct);
    foreach (q[i]) begin
      bit acc;
      int budget;
      acc = 1'b0;
      budget = 0;
      while (!acc) begin
        @(posedge clk);
        #1;
        bus.in_valid = ($urandom_range(99) < vpct);
        bus.in_data  = q[i];
        @(negedge clk);
        acc = bus.in_valid && bus.in_ready;
        budget++;
        if (!acc && budget > 2000) begin
          check("send_timeout", 32'd0, 32'd1);
          bus.in_valid = 1'b0;
          return;
        end
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_left", exp_q.size(), 32'd0);
  endtask

  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = ($urandom_range(99) < rdy_pct);
    end
  end

  // Output scoreboard, plus hold check for data under backpressure.
  always @(negedge clk) begin
    logic [7:0] e;
    if (mon_en && rst_n) begin
      if (prev_stall) check("hold_data", bus.out_data, prev_data);
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_byte", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("out_data", bus.out_data, e);
        end
        check("out_last", bus.out_last, (rx_cnt % 16) == 15);
        rx_cnt++;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    logic [7:0] t1 [16];
    logic [7:0] t2 [16];
    blk_t       fips;

    t1 = '{8'h00, 8'h0D, 8'h0A, 8'h07, 8'h04, 8'h01, 8'h0E, 8'h0B,
           8'h08, 8'h05, 8'h02, 8'h0F, 8'h0C, 8'h09, 8'h06, 8'h03};
    t2 = '{8'h10, 8'h1D, 8'h1A, 8'h17, 8'h14, 8'h11, 8'h1E, 8'h1B,
           8'h18, 8'h15, 8'h12, 8'h1F, 8'h1C, 8'h19, 8'h16, 8'h13};
    fips = '{8'hd4, 8'h27, 8'h11, 8'hae, 8'he0, 8'hbf, 8'h98, 8'hf1,
             8'hb8, 8'hb4, 8'h5d, 8'he5, 8'h1e, 8'h41, 8'h52, 8'h30};
    for (int k = 0; k < 16; k++) begin
      vec1[k] = '{din: 8'(k),        dout: t1[k], last: (k == 15)};
      vec2[k] = '{din: 8'(8'h10 + k), dout: t2[k], last: (k == 15)};
    end

    rst_n = 1'b1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready",  bus.in_ready,  32'd1);
    check("rst_out_valid", bus.out_valid, 32'd0);
    check("rst_out_last",  bus.out_last,  32'd0);
    check("rst_out_data",  bus.out_data,  32'd0);
    rst_n = 1'b1;
    rdy_pct = 100;

    // Table-driven block 0x00..0x0F with exact latency.
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      #1;
      bus.in_valid = 1'b1;
      bus.in_data  = vec1[i].din;
      @(negedge clk);
      check("t1_in_ready", bus.in_ready, 32'd1);
      check("t1_early_valid", bus.out_valid, 32'd0);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("t1_valid", bus.out_valid, 32'd1);
      check("t1_data",  bus.out_data,  vec1[i].dout);
      check("t1_last",  bus.out_last,  vec1[i].last);
      @(posedge clk);
    end
    @(negedge clk);
    check("t1_valid_end", bus.out_valid, 32'd0);

    // FIPS-197 round trip plus random states.
    mon_en = 1'b1;
    rx_cnt = 0;
    tx_q.delete();
    add_block(fips);
    for (int b = 0; b < 1000; b++) add_rand_block();
    send_bytes(tx_q, 100);
    wait_drain(100);

    // Three blocks with the sink stalled for the first 40 cycles.
    rdy_pct = 0;
    rx_cnt = 0;
    tx_q.delete();
    for (int b = 0; b < 3; b++) add_rand_block();
    fork
      send_bytes(tx_q, 100);
      begin
        @(posedge clk);
        for (int c = 0; c <= 60; c++) begin
          @(negedge clk);
          if (c == 31) check("t3_ready_b31", bus.in_ready, 32'd1);
          if (c == 32) check("t3_ready_full", bus.in_ready, 32'd0);
          if (c == 39) check("t3_valid_stall", bus.out_valid, 32'd1);
          if (c == 55) check("t3_ready_b15", bus.in_ready, 32'd0);
          if (c == 56) check("t3_ready_back", bus.in_ready, 32'd1);
          if (c == 39) rdy_pct = 100;
        end
      end
    join
    wait_drain(200);
    check("t3_rx_count", rx_cnt, 32'd48);

    // Random valid/ready over 200 blocks.
    rdy_pct = 50;
    rx_cnt = 0;
    tx_q.delete();
    for (int b = 0; b < 200; b++) add_rand_block();
    send_bytes(tx_q, 50);
    wait_drain(4000);
    check("t4_rx_count", rx_cnt, 32'd3200);

    // flush with block 1 partly read and block 2 partly written.
    rdy_pct = 0;
    rx_cnt = 0;
    tx_q.delete();
    add_rand_block();
    send_bytes(tx_q, 100);
    rdy_pct = 100;
    tx_q.delete();
    for (int k = 0; k < 7; k++) tx_q.push_back(8'($urandom));
    send_bytes(tx_q, 100);
    mon_en = 1'b0;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    check("t5_flush_valid", bus.out_valid, 32'd0);
    check("t5_flush_ready", bus.in_ready,  32'd1);
    exp_q.delete();
    rx_cnt = 0;
    mon_en = 1'b1;
    tx_q.delete();
    for (int k = 0; k < 16; k++) begin
      tx_q.push_back(vec2[k].din);
      exp_q.push_back(vec2[k].dout);
    end
    send_bytes(tx_q, 100);
    wait_drain(100);

    // Asynchronous reset between clock edges, mid-block.
    mon_en = 1'b0;
    rdy_pct = 0;
    tx_q.delete();
    for (int k = 0; k < 16; k++) tx_q.push_back(vec2[k].din);
    for (int k = 0; k < 5; k++) tx_q.push_back(8'($urandom));
    send_bytes(tx_q, 100);
    @(negedge clk);
    check("t6_pre_valid", bus.out_valid, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_in_ready",  bus.in_ready,  32'd1);
    check("t6_rst_out_valid", bus.out_valid, 32'd0);
    check("t6_rst_out_data",  bus.out_data,  32'd0);
    check("t6_rst_out_last",  bus.out_last,  32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    rx_cnt = 0;
    mon_en = 1'b1;
    rdy_pct = 100;
    tx_q.delete();
    add_rand_block();
    send_bytes(tx_q, 100);
    wait_drain(100);
    check("t6_rx_count", rx_cnt, 32'd16);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
